// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with scan-level debounce and a
// decimal accumulator. Completed numbers go to the CPU over valid/ready.
module keypad_entry #(
  parameter int SCAN_TICKS     = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_sel,
  input  logic [3:0] col_in,
  output logic [7:0] entry,
  output logic [7:0] number,
  output logic       number_valid,
  input  logic       number_ready,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       err
);

  localparam int            TW       = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]    DB       = 4'(DEBOUNCE_SCANS);

  localparam logic [3:0] CODE_CLEAR = 4'd10;
  localparam logic [3:0] CODE_BACK  = 4'd11;
  localparam logic [3:0] CODE_ENTER = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSING,
    S_HELD,
    S_RELEASING
  } state_t;

  // Position-to-legend map: rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
  function automatic logic [3:0] legend(input logic [3:0] pos);
    case (pos)
      4'd0:    legend = 4'd1;
      4'd1:    legend = 4'd2;
      4'd2:    legend = 4'd3;
      4'd3:    legend = 4'hA;
      4'd4:    legend = 4'd4;
      4'd5:    legend = 4'd5;
      4'd6:    legend = 4'd6;
      4'd7:    legend = 4'hB;
      4'd8:    legend = 4'd7;
      4'd9:    legend = 4'd8;
      4'd10:   legend = 4'd9;
      4'd11:   legend = 4'hC;
      4'd12:   legend = 4'hE;
      4'd13:   legend = 4'd0;
      4'd14:   legend = 4'hF;
      default: legend = 4'hD;
    endcase
  endfunction

  logic [3:0]    col_s1_q, col_s2_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    row_q;
  logic [3:0]    row_sel_q;
  logic [11:0]   snap_q;
  logic [15:0]   scan_q;
  logic          scan_done_q;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    pos_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  logic [7:0]    entry_q, number_q;
  logic          number_valid_q;
  logic          err_q;

  logic [4:0]    cls_cnt;
  logic [3:0]    cls_pos;
  logic          is_none, is_key;
  logic [11:0]   prod;
  logic          xfer;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
    end else begin
      // NOTE: non-blocking here so each flop samples the other's old value; blocking would collapse the two stages into one.
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
    end
  end

  // Row rotation, per-row column sampling and full-scan snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      row_q       <= '0;
      row_sel_q   <= 4'b0001;
      snap_q      <= '0;
      scan_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (tick_q == TICK_MAX) begin
        tick_q    <= '0;
        row_q     <= row_q + 2'd1;
        row_sel_q <= {row_sel_q[2:0], row_sel_q[3]};
        case (row_q)
          2'd0: snap_q[3:0]  <= col_s2_q;
          2'd1: snap_q[7:4]  <= col_s2_q;
          2'd2: snap_q[11:8] <= col_s2_q;
          default: begin
            scan_q      <= {col_s2_q, snap_q};
            scan_done_q <= 1'b1;
          end
        endcase
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  // Classify the latest full scan as NONE, a single KEY(p), or MULTI.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    cls_cnt = '0;
    cls_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_q[i]) begin
        cls_cnt = cls_cnt + 5'd1;
        cls_pos = 4'(i);
      end
    end
    is_none = (cls_cnt == 5'd0);
    is_key  = (cls_cnt == 5'd1);
  end

  // Debounce FSM: advances once per completed scan, emits one press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pos_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done_q) begin
        case (state_q)
          S_IDLE: begin
            if (is_key) begin
              pos_q <= cls_pos;
              if (DB == 4'd1) begin
                key_valid_q <= 1'b1;
                key_code_q  <= legend(cls_pos);
                cnt_q       <= '0;
                state_q     <= S_HELD;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= S_PRESSING;
              end
            end
          end
          S_PRESSING: begin
            if (is_key && cls_pos == pos_q) begin
              if (cnt_q + 4'd1 == DB) begin
                key_valid_q <= 1'b1;
                key_code_q  <= legend(pos_q);
                cnt_q       <= '0;
                state_q     <= S_HELD;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else if (is_key) begin
              pos_q <= cls_pos;
              cnt_q <= 4'd1;
            end else begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
          S_HELD: begin
            if (is_none) begin
              if (DB == 4'd1) begin
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= S_RELEASING;
              end
            end
          end
          default: begin
            if (is_none) begin
              if (cnt_q + 4'd1 == DB) begin
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_HELD;
            end
          end
        endcase
      end
    end
  end

  // Digit append computed at 12 bits so overflow past 255 is detectable.
  always_comb begin
    prod = {4'd0, entry_q} * 12'd10 + {8'd0, key_code_q};
    xfer = number_valid_q & number_ready;
  end

  // Accumulator and CPU handshake, acting on each accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q        <= '0;
      number_q       <= '0;
      number_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (xfer) begin
        number_valid_q <= 1'b0;
      end
      if (key_valid_q) begin
        if (key_code_q <= 4'd9) begin
          if (prod <= 12'd255) begin
            entry_q <= prod[7:0];
          end else begin
            err_q <= 1'b1;
          end
        end else if (key_code_q == CODE_CLEAR) begin
          entry_q <= '0;
        end else if (key_code_q == CODE_BACK) begin
          entry_q <= entry_q / 8'd10;
        end else if (key_code_q == CODE_ENTER) begin
          if (!number_valid_q || xfer) begin
            // Later assignment wins: an Enter on a transfer edge keeps valid high.
            number_q       <= entry_q;
            number_valid_q <= 1'b1;
            entry_q        <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign row_sel      = row_sel_q;
  assign entry        = entry_q;
  assign number       = number_q;
  assign number_valid = number_valid_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign err          = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed keypad presses against a scoreboard of
// hand-computed accumulator results, plus scan, debounce and reset checks.
module tb_keypad_entry;

  localparam int ST   = 8;
  localparam int DBS  = 2;
  localparam int SCAN = 4 * ST;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_sel;
  logic [3:0] col_in;
  logic [7:0] entry, number;
  logic       number_valid;
  logic       number_ready = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       err;
  logic [15:0] keys = '0;

  typedef struct {
    logic [3:0] code;
    logic [7:0] entry;
    logic       err;
    logic [7:0] number;
    logic       nv;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   kv_count = 0;
  int   n_push = 0;

  keypad_entry #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DBS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_sel      (row_sel),
    .col_in       (col_in),
    .entry        (entry),
    .number       (number),
    .number_valid (number_valid),
    .number_ready (number_ready),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row drive onto its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && row_sel[r]) col_in[c] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Legend code to keypad position (inverse of the key layout).
  function automatic int pos_of(input logic [3:0] code);
    case (code)
      4'd1: return 0;   4'd2: return 1;   4'd3: return 2;   4'hA: return 3;
      4'd4: return 4;   4'd5: return 5;   4'd6: return 6;   4'hB: return 7;
      4'd7: return 8;   4'd8: return 9;   4'd9: return 10;  4'hC: return 11;
      4'hE: return 12;  4'd0: return 13;  4'hF: return 14;  default: return 15;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(input logic [3:0] code);
    logic [15:0] one;
    one = 16'd1;
    return one << pos_of(code);
  endfunction

  task automatic push(input logic [3:0] code, input logic [7:0] e, input logic er,
                      input logic [7:0] num, input logic nv);
    exp_t x;
    x.code = code; x.entry = e; x.err = er; x.number = num; x.nv = nv;
    exp_q.push_back(x);
    n_push++;
  endtask

  // Clean press: held 3 scans, released 3 scans, with its expected result.
  task automatic press(input logic [3:0] code, input logic [7:0] e, input logic er,
                       input logic [7:0] num, input logic nv);
    push(code, e, er, num, nv);
    keys = mask_of(code);
    repeat (3*SCAN) @(negedge clk);
    keys = '0;
    repeat (3*SCAN) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_sel"},   row_sel, 4'b0001);
    check({tag, "_entry"},     entry, 0);
    check({tag, "_number"},    number, 0);
    check({tag, "_nv"},        number_valid, 0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_code"},  key_code, 0);
    check({tag, "_err"},       err, 0);
  endtask

  // Monitor: every key_valid pulse pops one expectation and checks the result.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && key_valid) begin
        kv_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got code %0d expected no press", key_code);
        end else begin
          x = exp_q.pop_front();
          check("key_code", key_code, x.code);
          @(negedge clk);
          check("key_valid_width", key_valid, 0);
          check("entry", entry, x.entry);
          check("err", err, x.err);
          check("number", number, x.number);
          check("number_valid", number_valid, x.nv);
          @(negedge clk);
          check("err_width", err, 0);
        end
      end
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;

    // Row rotation: one row per ST cycles, wrapping after a full scan.
    for (int n = 0; n <= 40; n++) begin
      if (n % ST == 0 || n % ST == ST - 1)
        check("row_sel_rotate", row_sel, 4'b0001 << ((n / ST) % 4));
      @(negedge clk);
    end

    // Entry and handshake.
    press(4'd1, 8'd1,   1'b0, 8'd0,   1'b0);
    press(4'd2, 8'd12,  1'b0, 8'd0,   1'b0);
    press(4'd8, 8'd128, 1'b0, 8'd0,   1'b0);
    press(4'hF, 8'd0,   1'b0, 8'd128, 1'b1);
    check("nv_before_ready", number_valid, 1);
    number_ready = 1'b1;
    @(negedge clk);
    number_ready = 1'b0;
    check("nv_after_ready", number_valid, 0);
    number_ready = 1'b1;
    @(negedge clk);
    number_ready = 1'b0;
    check("ready_when_idle", number_valid, 0);

    // Overflow and editing.
    press(4'd2, 8'd2,  1'b0, 8'd128, 1'b0);
    press(4'd5, 8'd25, 1'b0, 8'd128, 1'b0);
    press(4'd6, 8'd25, 1'b1, 8'd128, 1'b0);
    press(4'hB, 8'd2,  1'b0, 8'd128, 1'b0);
    press(4'hA, 8'd0,  1'b0, 8'd128, 1'b0);

    // Bounce: key 5 toggling each scan never stays stable for two scans.
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? mask_of(4'd5) : '0;
      repeat (SCAN) @(negedge clk);
    end
    keys = '0;
    repeat (3*SCAN) @(negedge clk);
    check("bounce_no_press", kv_count, n_push);

    // Two keys together classify as MULTI and are ignored.
    keys = mask_of(4'd1) | mask_of(4'd2);
    repeat (4*SCAN) @(negedge clk);
    keys = '0;
    repeat (3*SCAN) @(negedge clk);
    check("multi_no_press", kv_count, n_push);

    // Long hold yields exactly one press.
    push(4'd7, 8'd7, 1'b0, 8'd128, 1'b0);
    keys = mask_of(4'd7);
    repeat (12*SCAN) @(negedge clk);
    keys = '0;
    repeat (3*SCAN) @(negedge clk);
    check("long_hold_single", kv_count, n_push);

    // Enter collisions.
    press(4'hA, 8'd0,  1'b0, 8'd128, 1'b0);
    press(4'd4, 8'd4,  1'b0, 8'd128, 1'b0);
    press(4'd2, 8'd42, 1'b0, 8'd128, 1'b0);
    press(4'hF, 8'd0,  1'b0, 8'd42,  1'b1);
    press(4'd1, 8'd1,  1'b0, 8'd42,  1'b1);
    press(4'd7, 8'd17, 1'b0, 8'd42,  1'b1);
    press(4'hF, 8'd17, 1'b1, 8'd42,  1'b1);

    // Retry Enter with ready high on the accumulator's edge.
    push(4'hF, 8'd0, 1'b0, 8'd17, 1'b1);
    keys = mask_of(4'hF);
    found = 1'b0;
    for (int i = 0; i < 4*SCAN; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("retry_enter_seen", found, 1);
    number_ready = 1'b1;
    @(negedge clk);
    number_ready = 1'b0;
    repeat (2*SCAN) @(negedge clk);
    keys = '0;
    repeat (3*SCAN) @(negedge clk);

    // Reset mid-operation: entry 12, number pending, FSM in PRESSING.
    press(4'd1, 8'd1,  1'b0, 8'd17, 1'b1);
    press(4'd2, 8'd12, 1'b0, 8'd17, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2*SCAN; i++) begin
      @(negedge clk);
      if (row_sel == 4'b1000) begin
        found = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 2*ST && found; i++) begin
      @(negedge clk);
      if (row_sel == 4'b0001) break;
    end
    check("scan_aligned", found, 1);
    keys = mask_of(4'd3);
    repeat (44) @(negedge clk);
    check("pre_reset_entry", entry, 12);
    check("pre_reset_nv", number_valid, 1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4*SCAN) @(negedge clk);
    check("post_reset_no_press", kv_count, n_push);
    check("post_reset_entry", entry, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
